// File: rtl/riscv_pkg.sv
// Shared RV32 fetch-path definitions: data width, memory word-address
// width and the {pc, instr} entry carried through the fetch buffer.
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int IMEM_ADDR_W = 30;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO of fetched {pc, instr} pairs sitting between the memory
// response and decode. Flush empties it in one cycle and wins over push/pop.
module fetch_skid_buffer
    import riscv_pkg::*;
(
    input  logic         clock,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         pop_ok;
    logic         push_ok;

    // Never pop an empty buffer; only push into a full one when a slot frees.
    assign pop_ok  = pop && (count != 2'd0);
    assign push_ok = push && ((count != 2'd2) || pop_ok);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push_ok) - 2'(pop_ok);
        end
    end

    // Entry storage; contents are meaningless while count is zero.
    always_ff @(posedge clock) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: sequential PC generation, one-cycle-latency
// instruction memory interface, and a 2-entry buffer toward decode.
// Redirects flush buffered/in-flight work and re-issue in the same cycle.
// Optional macro FETCH_MISALIGN_TRAP_EN: a redirect to a non-word-aligned
// target raises fetch_fault and halts fetch until an aligned redirect.
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    output logic [IMEM_ADDR_W-1:0] imem_address,
    output logic                   imem_clken,
    input  logic [XLEN-1:0]        imem_q,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   if_valid,
    input  logic                   if_ready,
    output logic [XLEN-1:0]        if_instr,
    output logic [XLEN-1:0]        if_pc,
    output logic                   fetch_fault
);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic [XLEN-1:0] redir_target;
    logic [XLEN-1:0] issue_pc;
    logic            inflight;
    logic            issue;
    logic            deq;
    logic            redir_ok;
    logic            fault_q;
    logic [1:0]      fifo_count;
    logic [2:0]      occ;
    fetch_entry_t    head;
    fetch_entry_t    resp;

    assign redir_target = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redir_ok = (redirect_pc[1:0] == 2'b00);

    // Fault is sticky until the next redirect; that redirect decides its new value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)            fault_q <= 1'b0;
        else if (redirect_valid) fault_q <= !redir_ok;
    end
`else
    // Low target bits are simply dropped; the fault output is tied off.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign redir_ok             = 1'b1;
    assign fault_q              = 1'b0;
`endif

    assign fetch_fault = fault_q;
    assign if_valid    = (fifo_count != 2'd0);
    assign deq         = if_valid && if_ready;

    // Outstanding work once this cycle's dequeue retires: buffered + in flight.
    assign occ = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, deq};

    // Issue decision. Reset gates it combinationally so the memory enable
    // drops the moment reset_n falls. A redirect flushes everything, so it
    // issues regardless of occupancy (unless its target traps).
    always_comb begin
        issue = 1'b0;
        if (reset_n) begin
            if (redirect_valid) issue = redir_ok;
            else                issue = (occ < 3'd2) && !fault_q;
        end
    end

    assign issue_pc     = redirect_valid ? redir_target : fetch_pc;
    assign imem_address = issue_pc[XLEN-1:2];
    assign imem_clken   = issue;

    // PC advance and in-flight tracking; the read data lands one cycle later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= issue_pc;
                fetch_pc    <= issue_pc + 32'd4;
            end
        end
    end

    // A response arriving in a redirect cycle belongs to the old stream.
    assign resp = '{pc: inflight_pc, instr: imem_q};

    fetch_skid_buffer u_buf (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .push      (inflight && !redirect_valid),
        .push_data (resp),
        .pop       (deq),
        .head      (head),
        .count     (fifo_count)
    );

    assign if_instr = head.instr;
    assign if_pc    = head.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios with
// literal expectations plus a randomized phase, all checked every cycle
// against a stream-level reference model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [29:0] imem_address;
    logic        imem_clken;
    logic [31:0] imem_q = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_fault;

    always #5 clock = ~clock;

    instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_address   (imem_address),
        .imem_clken     (imem_clken),
        .imem_q         (imem_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fetch_fault    (fetch_fault)
    );

    // Memory contents: word i holds 32'h1000_0000 + i.
    function automatic logic [31:0] memf(input logic [29:0] a);
        return 32'h1000_0000 + {2'b00, a};
    endfunction

    // One-cycle read latency memory.
    always @(posedge clock) if (imem_clken) imem_q <= memf(imem_address);

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] acc_pc[$];
    logic [31:0] acc_in[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input int idx, input logic [31:0] pc, input logic [31:0] ins);
        if (acc_pc.size() <= idx) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: only %0d accepted, expected index %0d", name, acc_pc.size(), idx);
        end else begin
            chk({name, "_pc"}, acc_pc[idx], pc);
            chk({name, "_instr"}, acc_in[idx], ins);
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic rdy);
        @(negedge clock);
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
    endtask

    // Reference model: the accepted stream is consecutive words from the last
    // start point (reset or redirect); decode sees it two cycles after the
    // start and, with two fetches kept outstanding, never loses it afterwards.
    logic [31:0] m_exp;
    logic [31:0] m_fetch;
    int          m_since;
    logic        m_fault;

    initial begin : compare
        logic        exp_v, xfer, exp_c, trapped;
        logic [31:0] tgt;
        m_exp = RST_PC; m_fetch = RST_PC; m_since = 0; m_fault = 1'b0;
        forever begin
            @(negedge clock);
            #2;
            if (!reset_n) begin
                chk("rst_valid", {31'b0, if_valid}, 32'd0);
                chk("rst_clken", {31'b0, imem_clken}, 32'd0);
                chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
                m_exp = RST_PC; m_fetch = RST_PC; m_since = 0; m_fault = 1'b0;
            end else begin
                exp_v = (m_since >= 2) && !m_fault;
                xfer  = exp_v && if_ready;
                chk("if_valid", {31'b0, if_valid}, {31'b0, exp_v});
                if (exp_v) begin
                    chk("if_pc", if_pc, m_exp);
                    chk("if_instr", if_instr, memf(m_exp[31:2]));
                end
                if (xfer) begin
                    acc_pc.push_back(if_pc);
                    acc_in.push_back(if_instr);
                    m_exp = m_exp + 32'd4;
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                chk("fault", {31'b0, fetch_fault}, {31'b0, m_fault});
`else
                chk("fault", {31'b0, fetch_fault}, 32'd0);
`endif
                if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    trapped = (redirect_pc[1:0] != 2'b00);
`else
                    trapped = 1'b0;
`endif
                    chk("rd_clken", {31'b0, imem_clken}, {31'b0, !trapped});
                    if (!trapped) chk("rd_addr", {2'b00, imem_address}, {2'b00, redirect_pc[31:2]});
                    if (trapped) m_fault = 1'b1;
                    else begin
                        m_fault = 1'b0;
                        tgt     = {redirect_pc[31:2], 2'b00};
                        m_exp   = tgt;
                        m_fetch = tgt + 32'd4;
                    end
                    m_since = 1;
                end else begin
                    exp_c = m_fault ? 1'b0 : ((m_since < 2) ? 1'b1 : xfer);
                    chk("clken", {31'b0, imem_clken}, {31'b0, exp_c});
                    if (!m_fault) chk("addr", {2'b00, imem_address}, {2'b00, m_fetch[31:2]});
                    if (exp_c) m_fetch = m_fetch + 32'd4;
                    if (m_since < 2) m_since++;
                end
            end
        end
    end

    initial begin : stim
        int          pick;
        logic [31:0] rpc;
        logic        rv, rdy;
        reset_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // Straight-line fetch from reset.
        repeat (8) drive(1'b0, 32'h0, 1'b1);
        lit("p1_0", 0, 32'h0000_0000, 32'h1000_0000);
        lit("p1_1", 1, 32'h0000_0004, 32'h1000_0001);
        lit("p1_2", 2, 32'h0000_0008, 32'h1000_0002);

        // Decode stall, then resume without gap or duplicate.
        repeat (5) drive(1'b0, 32'h0, 1'b0);
        acc_pc.delete(); acc_in.delete();
        repeat (4) drive(1'b0, 32'h0, 1'b1);
        lit("p2_resume", 0, 32'h0000_001C, 32'h1000_0007);

        // Redirect while the buffer is full.
        repeat (3) drive(1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h0000_0100, 1'b0);
        #2;
        chk("p3_addr", {2'b00, imem_address}, 32'h0000_0040);
        chk("p3_clken", {31'b0, imem_clken}, 32'd1);
        #1;
        acc_pc.delete(); acc_in.delete();
        repeat (6) drive(1'b0, 32'h0, 1'b1);
        lit("p3_first", 0, 32'h0000_0100, 32'h1000_0040);

        // Redirect near the top of the address space; PC wraps to zero.
        drive(1'b1, 32'hFFFF_FFF8, 1'b1);
        #3;
        acc_pc.delete(); acc_in.delete();
        repeat (6) drive(1'b0, 32'h0, 1'b1);
        lit("p4_0", 0, 32'hFFFF_FFF8, 32'h4FFF_FFFE);
        lit("p4_1", 1, 32'hFFFF_FFFC, 32'h4FFF_FFFF);
        lit("p4_2", 2, 32'h0000_0000, 32'h1000_0000);

        // Misaligned redirect target.
        drive(1'b1, 32'h0000_0102, 1'b1);
        #3;
        acc_pc.delete(); acc_in.delete();
        repeat (4) drive(1'b0, 32'h0, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
        #2;
        chk("p5_fault", {31'b0, fetch_fault}, 32'd1);
        chk("p5_valid", {31'b0, if_valid}, 32'd0);
        chk("p5_clken", {31'b0, imem_clken}, 32'd0);
        chk("p5_none", acc_pc.size(), 32'd0);
        drive(1'b1, 32'h0000_0200, 1'b1);
        #3;
        acc_pc.delete(); acc_in.delete();
        repeat (4) drive(1'b0, 32'h0, 1'b1);
        #2;
        chk("p5_clear", {31'b0, fetch_fault}, 32'd0);
        lit("p5_first", 0, 32'h0000_0200, 32'h1000_0080);
`else
        #2;
        chk("p5_fault", {31'b0, fetch_fault}, 32'd0);
        lit("p5_first", 0, 32'h0000_0100, 32'h1000_0040);
`endif

        // Asynchronous reset mid-stream.
        repeat (3) drive(1'b0, 32'h0, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("p6_valid", {31'b0, if_valid}, 32'd0);
        chk("p6_clken", {31'b0, imem_clken}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        acc_pc.delete(); acc_in.delete();
        repeat (5) drive(1'b0, 32'h0, 1'b1);
        lit("p6_restart", 0, RST_PC, 32'h1000_0000);

        // Randomized redirects and back-pressure.
        repeat (1500) begin
            rv   = ($urandom % 12) == 0;
            rdy  = ($urandom % 4) != 0;
            pick = int'($urandom % 4);
            case (pick)
                0:       rpc = $urandom & 32'hFFFF_FFFC;
                1:       rpc = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000C);
                2:       rpc = $urandom;
                default: rpc = ($urandom % 1024) << 2;
            endcase
            drive(rv, rpc, rdy);
        end
        repeat (3) drive(1'b0, 32'h0, 1'b1);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
